// File: rtl/lfsr_mole_picker.sv
// rtl/lfsr_mole_picker.sv - XNOR LFSR random index picker with request/valid handshake
//
// Picks a mole index 0..N_CHOICES-1 on request. The index is drawn from a
// configurable XNOR LFSR by rejection sampling. It can optionally refuse to
// repeat the previous index. After MAX_TRIES rejections it falls back to a
// deterministic choice.
//
// Ports:
//   i_Clk        clock, rising edge
//   i_Rst_n      asynchronous active-low reset
//   i_En         free-run LFSR step enable while idle (player-timing entropy)
//   i_Seed_DV    load i_Seed this cycle (all-ones is replaced by zero)
//   i_Seed       seed value
//   i_Req        request the next index, sampled only while idle
//   o_Busy       high while a draw is in progress
//   o_Data_DV    one-cycle pulse, o_LFSR_Data valid
//   o_LFSR_Data  chosen index, held until the next o_Data_DV
//   o_State      current LFSR register

module lfsr_mole_picker #(
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
    parameter int                OUT_W     = 3,
    parameter int                N_CHOICES = 6,
    parameter int                NO_REPEAT = 1,
    parameter int                MAX_TRIES = 16
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic              i_En,
    input  logic              i_Seed_DV,
    input  logic [LFSR_W-1:0] i_Seed,
    input  logic              i_Req,
    output logic              o_Busy,
    output logic              o_Data_DV,
    output logic [OUT_W-1:0]  o_LFSR_Data,
    output logic [LFSR_W-1:0] o_State
);

    localparam int                TRY_W           = (MAX_TRIES < 2) ? 1 : $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0]  LP_TRY_LAST     = TRY_W'(MAX_TRIES - 1);
    localparam logic [OUT_W:0]    LP_N_EXT        = (OUT_W + 1)'(N_CHOICES);
    localparam logic [OUT_W-1:0]  LP_LAST_IDX     = OUT_W'(N_CHOICES - 1);
    localparam logic [OUT_W-1:0]  LP_ONE          = OUT_W'(1);
    localparam bit                LP_ALLOW_REPEAT = (NO_REPEAT == 0);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DRAW = 1'b1
    } state_t;

    state_t             r_State;
    state_t             w_Next_State;

    logic [LFSR_W-1:0]  r_LFSR;
    logic [TRY_W-1:0]   r_Try;
    logic               r_Have_Last;
    logic [OUT_W-1:0]   r_Data;
    logic               r_Data_DV;

    logic               w_Fb;
    logic               w_Step;
    logic [LFSR_W-1:0]  w_Seed_Safe;
    logic [OUT_W-1:0]   w_Cand;
    logic               w_In_Range;
    logic               w_Cand_Ok;
    logic               w_Accept;
    logic               w_Exhaust;
    logic [OUT_W-1:0]   w_Fallback;

    // XNOR feedback: the all-ones state maps onto itself, so it must never be entered.
    assign w_Fb        = ~^(r_LFSR & TAPS);
    assign w_Step      = (r_State == S_DRAW) || i_En;
    assign w_Seed_Safe = (i_Seed == {LFSR_W{1'b1}}) ? '0 : i_Seed;

    // The candidate comes from the pre-step value. This also holds when a seed lands mid-draw.
    assign w_Cand      = r_LFSR[OUT_W-1:0];
    assign w_In_Range  = ({1'b0, w_Cand} < LP_N_EXT);

    // r_Data doubles as the "last output" register. r_Have_Last qualifies it.
    assign w_Cand_Ok   = w_In_Range && (LP_ALLOW_REPEAT || !r_Have_Last || (w_Cand != r_Data));

    assign w_Fallback  = !r_Have_Last            ? '0 :
                         (r_Data == LP_LAST_IDX) ? '0 :
                                                   (r_Data + LP_ONE);

    // FSM state register
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_State <= S_IDLE;
        end else begin
            r_State <= w_Next_State;
        end
    end

    // FSM next state and draw decision
    always_comb begin
        w_Next_State = r_State;
        w_Accept     = 1'b0;
        w_Exhaust    = 1'b0;
        case (r_State)
            S_IDLE: begin
                if (i_Req) begin
                    w_Next_State = S_DRAW;
                end
            end
            S_DRAW: begin
                if (w_Cand_Ok) begin
                    w_Accept     = 1'b1;
                    w_Next_State = S_IDLE;
                end else if (r_Try >= LP_TRY_LAST) begin
                    // This rejection is the MAX_TRIES-th one.
                    w_Exhaust    = 1'b1;
                    w_Next_State = S_IDLE;
                end
            end
            default: begin
                w_Next_State = S_IDLE;
            end
        endcase
    end

    // LFSR register: a seed load has priority over stepping.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_LFSR <= '0;
        end else if (i_Seed_DV) begin
            r_LFSR <= w_Seed_Safe;
        end else if (w_Step) begin
            r_LFSR <= {r_LFSR[LFSR_W-2:0], w_Fb};
        end
    end

    // Try counter: cleared on request. A seed load mid-draw leaves it alone.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_Try <= '0;
        end else if ((r_State == S_IDLE) && i_Req) begin
            r_Try <= '0;
        end else if ((r_State == S_DRAW) && !w_Accept && !w_Exhaust && (r_Try < LP_TRY_LAST)) begin
            r_Try <= r_Try + TRY_W'(1);
        end
    end

    // Output index, last-output tracking and data-valid pulse
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_Data      <= '0;
            r_Have_Last <= 1'b0;
            r_Data_DV   <= 1'b0;
        end else begin
            r_Data_DV <= 1'b0;
            if (w_Accept) begin
                r_Data      <= w_Cand;
                r_Have_Last <= 1'b1;
                r_Data_DV   <= 1'b1;
            end else if (w_Exhaust) begin
                r_Data      <= w_Fallback;
                r_Have_Last <= 1'b1;
                r_Data_DV   <= 1'b1;
            end
        end
    end

    assign o_Busy      = (r_State == S_DRAW);
    assign o_Data_DV   = r_Data_DV;
    assign o_LFSR_Data = r_Data;
    assign o_State     = r_LFSR;

endmodule

// File: doc/lfsr_mole_picker.md
# lfsr_mole_picker

Parametrised random-choice generator for the whack-a-mole game. It replaces the fixed 6-bit free-running LFSR with a configurable-width, configurable-tap XNOR LFSR. It adds seed loading, lock-up protection and a request/valid handshake. Each request returns a mole index in the range 0..N_CHOICES-1, and it can optionally guarantee that the index differs from the previous one. It sits between the game controller, which requests the next mole, and the mole/LED decode logic.

## Interface
- LFSR_W, 16: LFSR register width, 3..32.
- TAPS, 16'hB400: feedback tap mask. Bit i set means r_LFSR[i] feeds the XNOR.
- OUT_W, 3: output index width.
- N_CHOICES, 6: number of legal indices, 2..2**OUT_W.
- NO_REPEAT, 1: 1 means consecutive outputs never repeat.
- MAX_TRIES, 16: draw attempts before the fallback is used, at least 1.
- i_Clk  in  1  clock. All logic is on the rising edge.
- i_Rst_n  in  1  reset. Asynchronous, active-low.
- i_En  in  1  free-run step enable while idle, used to gather entropy from player timing.
- i_Seed_DV  in  1  load i_Seed this cycle.
- i_Seed  in  LFSR_W  seed value.
- i_Req  in  1  request the next index. Sampled only in IDLE.
- o_Busy  out  1  high while in the DRAW state.
- o_Data_DV  out  1  one-cycle pulse; o_LFSR_Data is valid in that cycle.
- o_LFSR_Data  out  OUT_W  chosen index. Holds its value until the next o_Data_DV.
- o_State  out  LFSR_W  current LFSR register, for debug and the bench.

## Operation
- LFSR step: fb = ~^(r_LFSR & TAPS). The register shifts left: r_LFSR <= {r_LFSR[LFSR_W-2:0], fb}.
- All-ones is the XNOR lock-up state and must never be held.
  - A seed equal to all-ones loads 0 instead.
  - Any other seed loads verbatim.
- Register update priority:
  - i_Seed_DV first (load);
  - then stepping, which occurs when (state==DRAW) or i_En;
  - otherwise hold.
- FSM states:
  - IDLE: i_Req=1 -> DRAW and clear the try counter. o_Busy=0.
  - DRAW: each cycle evaluate the candidate c = r_LFSR[OUT_W-1:0], using the pre-step value. The LFSR steps in the same cycle.
    - Accept when c < N_CHOICES and (NO_REPEAT==0, or no previous output exists, or c != last).
    - On accept: o_LFSR_Data <= c, last <= c, have_last <= 1, pulse o_Data_DV, go to IDLE.
    - On reject: try counter +1.
    - On the MAX_TRIES-th rejection: output the fallback, pulse o_Data_DV, go to IDLE.
      - With a previous output: fallback = (last+1) mod N_CHOICES.
      - Without one: fallback = 0.
- i_Req in DRAW is ignored; there is no queueing.
- i_Seed_DV in DRAW loads the seed, and that cycle's candidate is still evaluated from the pre-load value. The try counter is not cleared.
- The try counter is wide enough for MAX_TRIES and saturates. Modulo arithmetic wraps at N_CHOICES without overflow at OUT_W bits.

## Timing
- Reset values:
  - r_LFSR=0, state IDLE, o_Busy=0, o_Data_DV=0, o_LFSR_Data=0, have_last=0, try counter 0, o_State=0.
- Reset asserted mid-DRAW aborts the draw immediately. No o_Data_DV is produced.
- i_Req high at edge k (IDLE) -> o_Busy high after edge k.
- An accept at the first candidate (edge k+1) -> o_Data_DV high after edge k+1. Minimum latency is 2 cycles from request to data.
- Worst-case latency is MAX_TRIES+1 cycles.
- o_Busy falls on the same edge that raises o_Data_DV.
- A new i_Req may be presented in the o_Data_DV cycle; it is accepted at that edge because state is IDLE.
- o_State reflects r_LFSR registered; there is no extra delay.

## Test plan
Bench configuration for all scenarios: LFSR_W=6, TAPS=6'b110000, OUT_W=3, N_CHOICES=6, NO_REPEAT=1, MAX_TRIES=4.

- Reset, i_En=1 for 6 cycles -> o_State sequence 000001, 000011, 000111, 001111, 011111, 111110.
- After reset, i_En=0, pulse i_Req -> o_Data_DV 2 cycles later with o_LFSR_Data=0 and o_State=000001.
  - Pulse i_Req again -> o_LFSR_Data=1.
- Seed 6'b000110 (candidate 6), then i_Req -> candidate 6 rejected, next candidate 5 (001101) accepted.
  - o_Data_DV at latency 3, o_LFSR_Data=5.
- Seed 6'b111111 -> o_State=000000 next cycle. Free-run 64 cycles -> o_State never 111111.
- MAX_TRIES=1, last=3, seed so the candidate is 3 -> o_LFSR_Data=4 at latency 2.
  - Repeat with last=5 -> output 0 (wrap).
- Assert i_Rst_n mid-DRAW -> o_Busy=0 and o_Data_DV=0 asynchronously, o_State=0.
  - A later request with no previous output may return 0 again, because have_last was cleared.
